// File: rtl/cam_frame_readout_ctrl_if.sv
// Capture, frame-RAM read and pixel-stream signals of the frame readout sequencer.
// master = sequencer side, slave = capture block / RAM / pixel sink side.
interface cam_frame_readout_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              cap_req;
  logic              cap_ready;
  logic [ADDR_W-1:0] ram_raddr;
  logic [31:0]       ram_rdata;
  logic              pix_valid;
  logic [15:0]       pix_data;
  logic              pix_ready;

  modport master (
    output cap_req, ram_raddr, pix_valid, pix_data,
    input  cap_ready, ram_rdata, pix_ready
  );

  modport slave (
    input  cap_req, ram_raddr, pix_valid, pix_data,
    output cap_ready, ram_rdata, pix_ready
  );
endinterface

// File: rtl/cam_frame_readout_ctrl.sv
// Requests one camera frame, reads the frame RAM word by word and streams each word
// as two RGB565 pixels (low half first); 4 cycles per word with pix_ready held high.
module cam_frame_readout_ctrl #(
  parameter int FRAME_WORDS = 38400,
  parameter int ADDR_W      = 16,
  parameter int TO_W        = 24
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      start,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout,
  cam_frame_readout_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE, REQ, ADDR, RDWAIT, PIX0, PIX1, RELEASE, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [TO_W-1:0]   TO_ONES   = '1;
  localparam logic [TO_W-1:0]   TO_PENULT = TO_ONES - TO_W'(1);

  state_t            state_q;
  logic [1:0]        sync_q;
  logic              cap_req_q;
  logic [ADDR_W-1:0] raddr_q;
  logic              pix_valid_q;
  logic [15:0]       pix_data_q;
  logic [15:0]       hi_q;
  logic              busy_q;
  logic              done_q;
  logic              timeout_q;
  logic              fail_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              rdy_s;
  logic              abortable;

  assign rdy_s     = sync_q[1];
  assign abortable = (state_q == REQ) || (state_q == ADDR) || (state_q == RDWAIT) ||
                     (state_q == PIX0) || (state_q == PIX1);

  // raddr_q doubles as the word counter: both always hold the current word index.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      cap_req_q   <= 1'b0;
      raddr_q     <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      hi_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_q      <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      sync_q    <= {sync_q[0], bus.cap_ready};
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      if (abort && abortable) begin
        state_q     <= RELEASE;
        cap_req_q   <= 1'b0;
        pix_valid_q <= 1'b0;
        fail_q      <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !abort) begin
              state_q   <= REQ;
              cap_req_q <= 1'b1;
              busy_q    <= 1'b1;
              to_cnt_q  <= '0;
              raddr_q   <= '0;
              fail_q    <= 1'b0;
            end
          end
          REQ: begin
            if (rdy_s) begin
              state_q <= ADDR;
            end else if (to_cnt_q == TO_PENULT) begin
              to_cnt_q  <= TO_ONES;
              state_q   <= RELEASE;
              cap_req_q <= 1'b0;
              timeout_q <= 1'b1;
              fail_q    <= 1'b1;
            end else begin
              to_cnt_q <= to_cnt_q + TO_W'(1);
            end
          end
          ADDR: state_q <= RDWAIT;
          RDWAIT: begin
            hi_q        <= bus.ram_rdata[31:16];
            pix_data_q  <= bus.ram_rdata[15:0];
            pix_valid_q <= 1'b1;
            state_q     <= PIX0;
          end
          PIX0: begin
            if (pix_valid_q && bus.pix_ready) begin
              pix_data_q <= hi_q;
              state_q    <= PIX1;
            end
          end
          PIX1: begin
            if (pix_valid_q && bus.pix_ready) begin
              pix_valid_q <= 1'b0;
              if (raddr_q == LAST_WORD) begin
                state_q   <= RELEASE;
                cap_req_q <= 1'b0;
              end else begin
                raddr_q <= raddr_q + ADDR_W'(1);
                state_q <= ADDR;
              end
            end
          end
          RELEASE: begin
            if (!rdy_s) begin
              state_q <= DONE;
              done_q  <= !fail_q;
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.cap_req   = cap_req_q;
  assign bus.ram_raddr = raddr_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_data  = pix_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign timeout       = timeout_q;

endmodule
